// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encodings, port ids and the default data-region base
package mem_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D} state_e;
  typedef enum logic {PORT_I, PORT_D} port_e;
  localparam logic [31:0] DATA_BASE_DEF = 32'h0000_1000;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and shared-memory bus of the arbiter
//   fetch : if_read, if_addr -> if_rdata, if_busywait
//   data  : d_read, d_write, d_addr, d_wdata -> d_rdata, d_busywait
//   memory: mem_read, mem_write, mem_addr, mem_wdata, mem_byteen <- mem_rdata, mem_busywait
//   slave = arbiter view, master = requesters/memory view
interface mem_arbiter_if #(parameter int MEM_AW = 32);
  logic              if_read;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_busywait;
  logic              d_read;
  logic              d_write;
  logic [7:0]        d_addr;
  logic [7:0]        d_wdata;
  logic [7:0]        d_rdata;
  logic              d_busywait;
  logic              mem_read;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byteen;
  logic [31:0]       mem_rdata;
  logic              mem_busywait;
  modport slave (
    input  if_read, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_busywait,
    output if_rdata, if_busywait, d_rdata, d_busywait,
           mem_read, mem_write, mem_addr, mem_wdata, mem_byteen
  );
  modport master (
    output if_read, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_busywait,
    input  if_rdata, if_busywait, d_rdata, d_busywait,
           mem_read, mem_write, mem_addr, mem_wdata, mem_byteen
  );
endinterface

// File: rtl/mem_arbiter_byte_lane.sv
// byte_lane: byte-lane helpers for the 8-bit data port on the 32-bit memory
//   lane_i   : byte lane (0 = bits [7:0])
//   byte_i   : store byte; rep_o = byte replicated on all four lanes
//   word_i   : memory word; byte_o = selected lane of word_i
//   onehot_o : byte enable with only lane_i set
module byte_lane (
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  input  logic [31:0] word_i,
  output logic [3:0]  onehot_o,
  output logic [31:0] rep_o,
  output logic [7:0]  byte_o
);
  assign onehot_o = 4'b0001 << lane_i;
  assign rep_o    = {4{byte_i}};
  assign byte_o   = 8'(word_i >> {lane_i, 3'b000});
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a byte data port onto one shared memory
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch/data request ports and shared-memory master bus
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] DATA_BASE = DATA_BASE_DEF,
  parameter int          MEM_AW    = 32
) (
  input  logic clk,
  input  logic reset,
  mem_arbiter_if.slave bus
);
  state_e            state_q, state_d;
  port_e             last_grant_q, port_q, grant;
  logic [MEM_AW-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [1:0]        lane_q;
  logic              write_q;
  logic [31:0]       if_rdata_q;
  logic [7:0]        d_rdata_q;
  logic              d_req, any_req, serve, capture;
  logic [3:0]        lane_oh;
  logic [31:0]       wdata_rep;
  logic [7:0]        rbyte;

  assign d_req   = bus.d_read | bus.d_write;
  assign any_req = bus.if_read | d_req;
  // on a tie the port that did not win last time gets the memory
  assign grant   = (bus.if_read && d_req) ? (last_grant_q == PORT_I ? PORT_D : PORT_I)
                                          : (d_req ? PORT_D : PORT_I);
  assign serve   = state_q == SERVE_I || state_q == SERVE_D;
  assign capture = serve && !bus.mem_busywait && !write_q;

  byte_lane u_lane (
    .lane_i   (lane_q),
    .byte_i   (wdata_q),
    .word_i   (bus.mem_rdata),
    .onehot_o (lane_oh),
    .rep_o    (wdata_rep),
    .byte_o   (rbyte)
  );

  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? (grant == PORT_D ? SERVE_D : SERVE_I) : IDLE;
      SERVE_I: state_d = bus.mem_busywait ? SERVE_I : DONE_I;
      SERVE_D: state_d = bus.mem_busywait ? SERVE_D : DONE_D;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_read    = serve & ~write_q;
    bus.mem_write   = serve & write_q;
    bus.mem_addr    = serve ? addr_q : '0;
    bus.mem_byteen  = serve ? (write_q ? lane_oh : 4'b1111) : 4'b0000;
    bus.mem_wdata   = (serve && write_q) ? wdata_rep : 32'd0;
    bus.if_busywait = bus.if_read && state_q != DONE_I;
    bus.d_busywait  = d_req && state_q != DONE_D;
    bus.if_rdata    = if_rdata_q;
    bus.d_rdata     = d_rdata_q;
  end

  // request fields are latched at grant so requesters may change inputs mid-transaction
  always_ff @(posedge clk)
    if (reset) begin
      last_grant_q <= PORT_I;
      port_q       <= PORT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      lane_q       <= '0;
      write_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else if (state_q == IDLE && any_req) begin
      last_grant_q <= grant;
      port_q       <= grant;
      addr_q       <= grant == PORT_D ? MEM_AW'(DATA_BASE + {24'd0, bus.d_addr[7:2], 2'b00})
                                      : MEM_AW'(bus.if_addr);
      wdata_q      <= bus.d_wdata;
      lane_q       <= bus.d_addr[1:0];
      write_q      <= grant == PORT_D && bus.d_write;
    end else if (capture) begin
      if (port_q == PORT_I) if_rdata_q <= bus.mem_rdata;
      else d_rdata_q <= rbyte;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   failed = 0;
  int   cnt;

  mem_arbiter_if #(.MEM_AW(32)) bus ();

  mem_arbiter #(.DATA_BASE(32'h0000_1000), .MEM_AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.if_read = 0; bus.if_addr = 0; bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_busywait = 0;
    tick(); tick();
    reset = 0;
    tick();
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_if_busy", bus.if_busywait, 0);
    check("rst_d_busy", bus.d_busywait, 0);

    // fetch, no wait states
    bus.if_read = 1; bus.if_addr = 32'h4; bus.mem_rdata = 32'h1234_5678;
    #1;
    check("f_busy_idle", bus.if_busywait, 1);
    tick();
    check("f_mem_read", bus.mem_read, 1);
    check("f_mem_write", bus.mem_write, 0);
    check("f_mem_addr", bus.mem_addr, 32'h4);
    check("f_byteen", bus.mem_byteen, 4'hf);
    check("f_busy_serve", bus.if_busywait, 1);
    tick();
    check("f_busy_done", bus.if_busywait, 0);
    check("f_mem_read_done", bus.mem_read, 0);
    check("f_addr_done", bus.mem_addr, 0);
    check("f_rdata", bus.if_rdata, 32'h1234_5678);
    bus.if_read = 0;
    tick();

    // store byte lane 2; inputs change mid-transaction to prove latching
    bus.d_write = 1; bus.d_addr = 8'h0A; bus.d_wdata = 8'h5C;
    #1;
    check("st_busy_idle", bus.d_busywait, 1);
    tick();
    bus.d_addr = 8'hFF; bus.d_wdata = 8'h00;
    #1;
    check("st_mem_write", bus.mem_write, 1);
    check("st_mem_read", bus.mem_read, 0);
    check("st_mem_addr", bus.mem_addr, 32'h0000_1008);
    check("st_byteen", bus.mem_byteen, 4'b0100);
    check("st_wdata", bus.mem_wdata, 32'h5C5C_5C5C);
    tick();
    check("st_busy_done", bus.d_busywait, 0);
    check("st_strobe_done", bus.mem_write, 0);
    check("st_wdata_done", bus.mem_wdata, 0);
    check("st_d_rdata_kept", bus.d_rdata, 0);
    bus.d_write = 0;
    tick();

    // read+write together counts as a write
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 8'h03; bus.d_wdata = 8'hA5;
    tick();
    check("rw_mem_write", bus.mem_write, 1);
    check("rw_mem_read", bus.mem_read, 0);
    check("rw_byteen", bus.mem_byteen, 4'b1000);
    check("rw_addr", bus.mem_addr, 32'h0000_1000);
    check("rw_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    bus.d_read = 0; bus.d_write = 0;
    tick(); tick();

    // load byte lane 3 with three wait states
    bus.d_read = 1; bus.d_addr = 8'h0B; bus.mem_rdata = 32'hAABB_CCDD; bus.mem_busywait = 1;
    #1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.d_busywait) break;
      cnt++;
      if (i == 1) begin
        check("ld_mem_read", bus.mem_read, 1);
        check("ld_mem_addr", bus.mem_addr, 32'h0000_1008);
        check("ld_byteen", bus.mem_byteen, 4'hf);
      end
      if (i == 4) bus.mem_busywait = 0;
      tick();
    end
    check("ld_busy_cycles", cnt, 5);
    check("ld_d_rdata", bus.d_rdata, 8'hAA);
    check("ld_if_rdata_kept", bus.if_rdata, 32'h1234_5678);
    check("ld_strobe_done", bus.mem_read, 0);
    bus.d_read = 0;
    tick();

    // ties after reset: data first, then alternate
    reset = 1; tick(); reset = 0;
    bus.if_read = 1; bus.if_addr = 32'h40; bus.d_read = 1; bus.d_addr = 8'h04;
    bus.mem_rdata = 32'h1122_3344;
    tick();
    check("tie1_addr", bus.mem_addr, 32'h0000_1004);
    check("tie1_if_busy", bus.if_busywait, 1);
    tick();
    check("tie1_d_busy", bus.d_busywait, 0);
    check("tie1_if_busy_done", bus.if_busywait, 1);
    check("tie1_d_rdata", bus.d_rdata, 8'h44);
    tick();
    tick();
    check("tie2_addr", bus.mem_addr, 32'h40);
    tick();
    check("tie2_if_rdata", bus.if_rdata, 32'h1122_3344);
    check("tie2_if_busy", bus.if_busywait, 0);
    tick();
    tick();
    check("tie3_addr", bus.mem_addr, 32'h0000_1004);
    bus.if_read = 0; bus.d_read = 0;
    tick(); tick();

    // reset during a stalled data read
    bus.d_read = 1; bus.d_addr = 8'h01; bus.mem_rdata = 32'hFFFF_FFFF; bus.mem_busywait = 1;
    tick();
    check("ab_mem_read", bus.mem_read, 1);
    tick();
    reset = 1;
    tick();
    check("ab_mem_read_off", bus.mem_read, 0);
    check("ab_mem_addr", bus.mem_addr, 0);
    check("ab_d_rdata", bus.d_rdata, 0);
    check("ab_if_rdata", bus.if_rdata, 0);
    reset = 0; bus.d_read = 0; bus.mem_busywait = 0;
    tick();
    check("ab_d_busy", bus.d_busywait, 0);
    check("ab_idle_strobe", bus.mem_read, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
